// File: rtl/flash_audio_reader_if.sv
// Bus bundle between the address sequencer / Avalon flash port / audio sink and
// flash_audio_reader.
//   slave  : the reader itself (consumes start/address/tick and flash responses,
//            drives the Avalon request and the audio outputs).
//   master : the surrounding system (sequencer, flash, sample-rate source).
// Signals:
//   start_flash, flash_mem_address_in  - word request from the sequencer
//   sample_tick                        - one-clk strobe at the audio sample rate
//   flash_mem_*                        - Avalon-MM read port to flash
//   audio_out, audio_done, busy        - playback outputs / status
interface flash_audio_reader_if #(
  parameter int unsigned ADDR_WIDTH   = 23,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16
) ();

  logic                    start_flash;
  logic [31:0]             flash_mem_address_in;
  logic                    sample_tick;
  logic                    flash_mem_read;
  logic [ADDR_WIDTH-1:0]   flash_mem_address;
  logic [3:0]              flash_mem_byteenable;
  logic                    flash_mem_waitrequest;
  logic [DATA_WIDTH-1:0]   flash_mem_readdata;
  logic                    flash_mem_readdatavalid;
  logic [SAMPLE_WIDTH-1:0] audio_out;
  logic                    audio_done;
  logic                    busy;

  modport slave (
    input  start_flash,
    input  flash_mem_address_in,
    input  sample_tick,
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid,
    output audio_out,
    output audio_done,
    output busy
  );

  modport master (
    output start_flash,
    output flash_mem_address_in,
    output sample_tick,
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid,
    input  audio_out,
    input  audio_done,
    input  busy
  );

endinterface

// File: rtl/flash_audio_reader.sv
// Responder side of the flash-address handshake in the speech synthesizer.
// A rising edge on start_flash captures a word address, one Avalon-MM read
// fetches a 32-bit word holding two packed samples, and the low then high half
// are played on successive sample ticks. audio_done pulses once per word so the
// sequencer can advance.
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - asynchronous, active-high
//   bus   - flash_audio_reader_if.slave (sequencer, Avalon read port, audio out)
module flash_audio_reader #(
  parameter int unsigned ADDR_WIDTH   = 23,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  flash_audio_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitData,
    StWaitTick0,
    StWaitTick1,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    start_flash_q;
  logic                    start_edge;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SAMPLE_WIDTH-1:0] audio_q;

  // Only the low ADDR_WIDTH bits of the sequencer address reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.flash_mem_address_in[31:ADDR_WIDTH];

  assign start_edge = bus.start_flash & ~start_flash_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; edges outside StIdle are dropped, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_edge)                   state_d = StReq;
      StReq:       if (!bus.flash_mem_waitrequest)   state_d = StWaitData;
      StWaitData:  if (bus.flash_mem_readdatavalid)  state_d = StWaitTick0;
      StWaitTick0: if (bus.sample_tick)              state_d = StWaitTick1;
      StWaitTick1: if (bus.sample_tick)              state_d = StDone;
      StDone:                                        state_d = StIdle;
      default:                                       state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.flash_mem_read       = (state_q == StReq);
    bus.flash_mem_address    = addr_q;
    bus.flash_mem_byteenable = 4'b1111;
    bus.audio_out            = audio_q;
    bus.audio_done           = (state_q == StDone);
    bus.busy                 = (state_q != StIdle);
  end

  // Datapath: edge register, address capture, data latch, sample output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_flash_q <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      audio_q       <= '0;
    end else begin
      start_flash_q <= bus.start_flash;
      if (state_q == StIdle && start_edge) begin
        addr_q <= bus.flash_mem_address_in[ADDR_WIDTH-1:0];
      end
      if (state_q == StWaitData && bus.flash_mem_readdatavalid) begin
        data_q <= bus.flash_mem_readdata;
      end
      // Low half plays first, high half on the following tick.
      if (state_q == StWaitTick0 && bus.sample_tick) begin
        audio_q <= data_q[SAMPLE_WIDTH-1:0];
      end
      if (state_q == StWaitTick1 && bus.sample_tick) begin
        audio_q <= data_q[DATA_WIDTH-1:SAMPLE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_flash_audio_reader.sv
// Self-checking bench for flash_audio_reader: a table of per-cycle vectors for
// the basic and stalled reads, then hand-written sequences for held start,
// reset mid-word, back-to-back words and an edge landing on audio_done.
module tb_flash_audio_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flash_audio_reader_if bus ();

  flash_audio_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] addr_in;
    logic        tick;
    logic        wr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_read;
    logic [22:0] e_addr;
    logic [15:0] e_audio;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // Flash responder / observer state for the hand-written sequences.
  int          reads, dones, cyc;
  logic        auto_tick;
  logic [15:0] prev_audio;
  logic [15:0] seen[$];
  logic [22:0] acc_addrs[$];

  function automatic vec_t v(logic rst, logic start, logic [31:0] addr_in, logic tick,
                             logic wr, logic rvalid, logic [31:0] rdata, logic e_read,
                             logic [22:0] e_addr, logic [15:0] e_audio, logic e_done,
                             logic e_busy);
    vec_t r;
    r.rst = rst; r.start = start; r.addr_in = addr_in; r.tick = tick; r.wr = wr;
    r.rvalid = rvalid; r.rdata = rdata; r.e_read = e_read; r.e_addr = e_addr;
    r.e_audio = e_audio; r.e_done = e_done; r.e_busy = e_busy;
    return r;
  endfunction

  // Flash contents model: word at address a.
  function automatic logic [31:0] fdata(logic [22:0] a);
    return {a[15:0] ^ 16'hFFFF, a[15:0] + 16'h1000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_seen(input string name, input int idx, input logic [15:0] exp);
    logic [31:0] act;
    act = (idx < seen.size()) ? {16'h0, seen[idx]} : 32'hDEAD_DEAD;
    check(name, act, {16'h0, exp});
  endtask

  task automatic check_acc(input string name, input int idx, input logic [22:0] exp);
    logic [31:0] act;
    act = (idx < acc_addrs.size()) ? {9'h0, acc_addrs[idx]} : 32'hDEAD_DEAD;
    check(name, act, {9'h0, exp});
  endtask

  // One clock: count accepted reads, answer them with readdatavalid one clk later,
  // count done pulses and record every audio_out change.
  task automatic step();
    logic        acc;
    logic [22:0] a;
    acc = bus.flash_mem_read && !bus.flash_mem_waitrequest;
    a   = bus.flash_mem_address;
    if (acc) begin
      reads++;
      acc_addrs.push_back(a);
    end
    @(posedge clk);
    #1;
    if (bus.audio_done) dones++;
    if (bus.audio_out !== prev_audio) seen.push_back(bus.audio_out);
    prev_audio = bus.audio_out;
    bus.flash_mem_readdatavalid = acc;
    bus.flash_mem_readdata      = acc ? fdata(a) : 32'h0;
    cyc++;
    if (auto_tick) bus.sample_tick = (cyc % 3 == 0);
  endtask

  task automatic clear_obs();
    reads = 0;
    dones = 0;
    seen.delete();
    acc_addrs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.start_flash = 1'b0;
    bus.flash_mem_address_in = '0;
    bus.sample_tick = 1'b0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdata = '0;
    bus.flash_mem_readdatavalid = 1'b0;
    auto_tick = 1'b0;
    cyc = 0;
    clear_obs();

    //                rst st addr_in   tk wr rv rdata          rd addr    audio    dn by
    tbl.push_back(v(1, 0, 32'h0,     0, 0, 0, 32'h0,         0, 23'h0,   16'h0,    0, 0));
    tbl.push_back(v(0, 1, 32'h123,   0, 0, 0, 32'h0,         1, 23'h123, 16'h0,    0, 1));
    tbl.push_back(v(0, 1, 32'h123,   0, 0, 0, 32'h0,         0, 23'h123, 16'h0,    0, 1));
    tbl.push_back(v(0, 1, 32'h0,     0, 0, 1, 32'hBEEF1234,  0, 23'h123, 16'h0,    0, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 0, 32'h0,         0, 23'h123, 16'h1234, 0, 1));
    tbl.push_back(v(0, 1, 32'h0,     0, 0, 0, 32'h0,         0, 23'h123, 16'h1234, 0, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 0, 32'h0,         0, 23'h123, 16'hBEEF, 1, 1));
    tbl.push_back(v(0, 1, 32'h0,     0, 0, 0, 32'h0,         0, 23'h123, 16'hBEEF, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,     1, 0, 0, 32'h0,         0, 23'h123, 16'hBEEF, 0, 0));
    tbl.push_back(v(0, 1, 32'h456,   0, 1, 0, 32'h0,         1, 23'h456, 16'hBEEF, 0, 1));
    tbl.push_back(v(0, 1, 32'h456,   1, 1, 0, 32'h0,         1, 23'h456, 16'hBEEF, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1, 32'h777, 0, 1, 0, 32'h0,       1, 23'h456, 16'hBEEF, 0, 1));
    tbl.push_back(v(0, 1, 32'h777,   1, 0, 0, 32'h0,         0, 23'h456, 16'hBEEF, 0, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 1, 32'h5555AAAA,  0, 23'h456, 16'hBEEF, 0, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 0, 32'h0,         0, 23'h456, 16'hAAAA, 0, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 0, 32'h0,         0, 23'h456, 16'h5555, 1, 1));
    tbl.push_back(v(0, 1, 32'h0,     1, 0, 0, 32'h0,         0, 23'h456, 16'h5555, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      reset                       = tbl[i].rst;
      bus.start_flash             = tbl[i].start;
      bus.flash_mem_address_in    = tbl[i].addr_in;
      bus.sample_tick             = tbl[i].tick;
      bus.flash_mem_waitrequest   = tbl[i].wr;
      bus.flash_mem_readdatavalid = tbl[i].rvalid;
      bus.flash_mem_readdata      = tbl[i].rdata;
      @(posedge clk);
      #1;
      check($sformatf("v%0d read", i),  {31'h0, bus.flash_mem_read},    {31'h0, tbl[i].e_read});
      check($sformatf("v%0d addr", i),  {9'h0, bus.flash_mem_address},  {9'h0, tbl[i].e_addr});
      check($sformatf("v%0d audio", i), {16'h0, bus.audio_out},         {16'h0, tbl[i].e_audio});
      check($sformatf("v%0d done", i),  {31'h0, bus.audio_done},        {31'h0, tbl[i].e_done});
      check($sformatf("v%0d busy", i),  {31'h0, bus.busy},              {31'h0, tbl[i].e_busy});
    end
    check("byteenable", {28'h0, bus.flash_mem_byteenable}, 32'hF);

    // Held start for 200 clks: one read, one done.
    bus.sample_tick = 1'b0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.start_flash = 1'b0;
    prev_audio = 16'h5555;
    step();
    clear_obs();
    auto_tick = 1'b1;
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h200;
    repeat (200) step();
    check("held reads", reads, 1);
    check("held dones", dones, 1);
    check_acc("held addr", 0, 23'h200);
    check("held nsamples", seen.size(), 2);
    check_seen("held s0", 0, 16'h1200);
    check_seen("held s1", 1, 16'hFDFF);
    check("held busy", {31'h0, bus.busy}, 0);

    // Reset while waiting for the second tick.
    auto_tick = 1'b0;
    bus.sample_tick = 1'b0;
    bus.start_flash = 1'b0;
    step();
    clear_obs();
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h301;
    step();
    step();
    step();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check("rst pre audio", {16'h0, bus.audio_out}, 32'h1301);
    check("rst pre busy", {31'h0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    check("rst audio", {16'h0, bus.audio_out}, 0);
    check("rst busy", {31'h0, bus.busy}, 0);
    check("rst read", {31'h0, bus.flash_mem_read}, 0);
    check("rst addr", {9'h0, bus.flash_mem_address}, 0);
    step();
    step();
    bus.start_flash = 1'b0;
    reset = 1'b0;
    step();
    check("rst no done", dones, 0);
    clear_obs();
    auto_tick = 1'b1;
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h302;
    for (int i = 0; i < 60 && dones < 1; i++) step();
    check("post-rst reads", reads, 1);
    check("post-rst dones", dones, 1);
    check_acc("post-rst addr", 0, 23'h302);
    check_seen("post-rst s0", 0, 16'h1302);
    check_seen("post-rst s1", 1, 16'hFCFD);

    // Back-to-back words.
    bus.start_flash = 1'b0;
    for (int i = 0; i < 3; i++) step();
    clear_obs();
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h123;
    for (int i = 0; i < 60 && dones < 1; i++) step();
    bus.start_flash = 1'b0;
    step();
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h124;
    for (int i = 0; i < 60 && dones < 2; i++) step();
    check("b2b reads", reads, 2);
    check("b2b dones", dones, 2);
    check_acc("b2b addr0", 0, 23'h123);
    check_acc("b2b addr1", 1, 23'h124);
    check("b2b nsamples", seen.size(), 4);
    check_seen("b2b s0", 0, 16'h1123);
    check_seen("b2b s1", 1, 16'hFEDC);
    check_seen("b2b s2", 2, 16'h1124);
    check_seen("b2b s3", 3, 16'hFEDB);

    // Edge arriving in the audio_done cycle is dropped.
    for (int i = 0; i < 3; i++) step();
    bus.start_flash = 1'b0;
    step();
    clear_obs();
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h400;
    step();
    bus.start_flash = 1'b0;
    for (int i = 0; i < 60 && dones < 1; i++) step();
    bus.start_flash = 1'b1;
    bus.flash_mem_address_in = 32'h500;
    repeat (12) step();
    check("done-edge reads", reads, 1);
    check("done-edge dones", dones, 1);
    check("done-edge busy", {31'h0, bus.busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
